// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state enum, default sizes and width helpers for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;
  localparam int DEF_DSIZE     = 8;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 4;
  function automatic int arb_idw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int arb_bcw(input int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after start, wrapping modulo N
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [N-1:0] rot;
  logic [IW:0]  off;
  logic [IW:0]  sum;
  // rotate so start sits at bit 0, take the lowest set bit, rotate the offset back
  always_comb begin
    rot = N'({req, req} >> start);
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = (IW + 1)'(i);
    sum = {1'b0, start} + off;
    found = |req;
    idx = IW'((sum >= (IW + 1)'(N)) ? sum - (IW + 1)'(N) : sum);
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NREQ producers
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int IDW       = arb_idw(NREQ),
  parameter int BCW       = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);
  arb_state_e     state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic           found;
  logic [IDW-1:0] pick_idx;
  logic           in_burst, g_valid, xfer, done;

  rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .req  (req_valid),
    .start(rr_ptr_q),
    .found(found),
    .idx  (pick_idx)
  );

  // next-state, burst counting and the owner-gated write-port mux
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    in_burst   = (state_q == ARB_BURST);
    g_valid    = req_valid[grant_id_q];
    xfer       = in_burst & g_valid & ~wfull;
    done       = ~g_valid | (xfer & (req_last[grant_id_q] | (beat_cnt_q + BCW'(1) == BCW'(MAX_BURST))));
    winc       = xfer;
    wdata      = req_data[grant_id_q*DSIZE +: DSIZE];
    if (!in_burst) begin
      if (found) begin
        grant_id_d = pick_idx;
        beat_cnt_d = '0;
        state_d    = ARB_BURST;
      end
    end else begin
      req_ready[grant_id_q] = ~wfull;
      beat_cnt_d = xfer ? beat_cnt_q + BCW'(1) : beat_cnt_q;
      if (done) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
      end
    end
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == ARB_BURST);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table-driven checks of the round-robin FIFO write arbiter
module tb_fifo_wr_arbiter;
  logic        wclk = 1'b0;
  logic        wrst_n = 1'b1;
  logic [3:0]  req_valid = '0, req_last = '0, req_ready;
  logic [31:0] req_data = '0;
  logic        wfull = 1'b0, winc, busy;
  logic [7:0]  wdata;
  logic [1:0]  grant_id;
  logic [2:0]  v3 = '0, l3 = '0, rdy3;
  logic [23:0] d3 = '0;
  logic        wf3 = 1'b0, winc3, busy3;
  logic [7:0]  wdata3;
  logic [1:0]  gid3;
  int          errors = 0, checks = 0;

  typedef struct {
    logic [3:0]  v, l;
    logic [31:0] d;
    logic        wf;
    logic [3:0]  rdy;
    logic        wi;
    logic [7:0]  wd;
    logic        bz;
    logic [1:0]  gid;
  } vec_t;
  vec_t vecs[$];

  fifo_wr_arbiter dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .grant_id(grant_id), .busy(busy)
  );

  fifo_wr_arbiter #(.NREQ(3), .IDW(2)) dut3 (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(v3), .req_data(d3),
    .req_last(l3), .req_ready(rdy3), .wfull(wf3), .winc(winc3),
    .wdata(wdata3), .grant_id(gid3), .busy(busy3)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] sl(input int g, input logic [7:0] b);
    return 32'(b) << (8 * g);
  endfunction

  function automatic void add(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                              input logic wf, input logic [3:0] rdy, input logic wi,
                              input logic [7:0] wd, input logic bz, input logic [1:0] gid);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.wf = wf; r.rdy = rdy; r.wi = wi; r.wd = wd; r.bz = bz; r.gid = gid;
    vecs.push_back(r);
  endfunction

  initial begin
    // round robin, all four valid, no last: 0,1,2,3 with 4 beats and an idle bubble each
    for (int g = 0; g < 4; g++) begin
      add(4'hF, 4'h0, 32'h33221100, 0, 4'h0, 0, 8'h00, 0, 2'd0);
      for (int b = 0; b < 4; b++)
        add(4'hF, 4'h0, 32'h33221100, 0, 4'(1 << g), 1, 8'(8'h11 * g), 1, 2'(g));
    end
    add(4'hF, 4'h0, 32'h33221100, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(4'hF, 4'h0, 32'h33221100, 0, 4'h1, 1, 8'h00, 1, 2'd0);
    add(4'h0, 4'h0, 32'h33221100, 0, 4'h1, 0, 8'h00, 1, 2'd0);
    add(4'h0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    // single requester 1: A1, A2, A3(last)
    add(4'h2, 4'h0, sl(1, 8'hA1), 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(4'h2, 4'h0, sl(1, 8'hA1), 0, 4'h2, 1, 8'hA1, 1, 2'd1);
    add(4'h2, 4'h0, sl(1, 8'hA2), 0, 4'h2, 1, 8'hA2, 1, 2'd1);
    add(4'h2, 4'h2, sl(1, 8'hA3), 0, 4'h2, 1, 8'hA3, 1, 2'd1);
    add(4'h0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    // backpressure on requester 2 after beat 1, 4 beats total
    add(4'h4, 4'h0, sl(2, 8'hB1), 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(4'h4, 4'h0, sl(2, 8'hB1), 0, 4'h4, 1, 8'hB1, 1, 2'd2);
    for (int s = 0; s < 3; s++)
      add(4'h4, 4'h0, sl(2, 8'hB2), 1, 4'h0, 0, 8'h00, 1, 2'd2);
    add(4'h4, 4'h0, sl(2, 8'hB2), 0, 4'h4, 1, 8'hB2, 1, 2'd2);
    add(4'h4, 4'h0, sl(2, 8'hB3), 0, 4'h4, 1, 8'hB3, 1, 2'd2);
    add(4'h4, 4'h0, sl(2, 8'hB4), 0, 4'h4, 1, 8'hB4, 1, 2'd2);
    add(4'h0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    // early drop of requester 0 (drop cycle also full), then pointer sits past 0
    add(4'h1, 4'h0, sl(0, 8'hC1), 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(4'h1, 4'h0, sl(0, 8'hC1), 0, 4'h1, 1, 8'hC1, 1, 2'd0);
    add(4'h1, 4'h0, sl(0, 8'hC2), 0, 4'h1, 1, 8'hC2, 1, 2'd0);
    add(4'h0, 4'h0, 32'h0, 1, 4'h0, 0, 8'h00, 1, 2'd0);
    add(4'h9, 4'h8, sl(3, 8'hC3) | sl(0, 8'hC4), 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(4'h9, 4'h8, sl(3, 8'hC3) | sl(0, 8'hC4), 0, 4'h8, 1, 8'hC3, 1, 2'd3);
    add(4'h1, 4'h1, sl(0, 8'hC4), 0, 4'h0, 0, 8'h00, 0, 2'd0);
    add(4'h1, 4'h1, sl(0, 8'hC4), 0, 4'h1, 1, 8'hC4, 1, 2'd0);
    add(4'h0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0, 2'd0);

    // reset state, held across clock edges with all requests pending
    #2 wrst_n = 1'b0;
    #1;
    chk("rst_busy", 0, 32'(busy), 0);
    chk("rst_gid", 0, 32'(grant_id), 0);
    req_valid = 4'hF;
    @(negedge wclk); @(negedge wclk);
    #1;
    chk("rst_ready", 0, 32'(req_ready), 0);
    chk("rst_winc", 0, 32'(winc), 0);
    chk("rst_busy_hold", 0, 32'(busy), 0);
    req_valid = 4'h0;
    @(negedge wclk) wrst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge wclk);
      req_valid = vecs[i].v; req_last = vecs[i].l; req_data = vecs[i].d; wfull = vecs[i].wf;
      #1;
      chk("ready", i, 32'(req_ready), 32'(vecs[i].rdy));
      chk("winc", i, 32'(winc), 32'(vecs[i].wi));
      chk("busy", i, 32'(busy), 32'(vecs[i].bz));
      if (vecs[i].bz) chk("grant_id", i, 32'(grant_id), 32'(vecs[i].gid));
      if (vecs[i].wi) chk("wdata", i, 32'(wdata), 32'(vecs[i].wd));
    end

    // reset mid-burst: requester 1 on beat 2, reset between edges
    @(negedge wclk); req_valid = 4'h2; req_data = sl(1, 8'hD1);
    @(negedge wclk); #1;
    chk("mid_gid", 0, 32'(grant_id), 1);
    chk("mid_winc1", 0, 32'(winc), 1);
    @(negedge wclk); req_data = sl(1, 8'hD2); #1;
    chk("mid_wdata2", 0, 32'(wdata), 32'hD2);
    #2 wrst_n = 1'b0;
    #1;
    chk("mid_rst_winc", 0, 32'(winc), 0);
    chk("mid_rst_busy", 0, 32'(busy), 0);
    chk("mid_rst_ready", 0, 32'(req_ready), 0);
    @(negedge wclk); req_valid = 4'h3; req_data = sl(0, 8'hE0) | sl(1, 8'hE1);
    @(negedge wclk) wrst_n = 1'b1;
    @(negedge wclk); #1;
    chk("post_rst_busy", 0, 32'(busy), 1);
    chk("post_rst_gid", 0, 32'(grant_id), 0);
    chk("post_rst_wdata", 0, 32'(wdata), 32'hE0);
    req_valid = 4'h0;
    @(negedge wclk); @(negedge wclk); #1;
    chk("post_rst_idle", 0, 32'(busy), 0);

    // NREQ=3 wrap: grants 2, 0, 2, 0 with requesters 0 and 2 (2 first alone)
    for (int s = 0; s < 8; s++) begin
      @(negedge wclk);
      v3 = (s < 2) ? 3'b100 : 3'b101;
      l3 = v3;
      d3 = 24'hC2_00_C0;
      #1;
      chk("n3_busy", s, 32'(busy3), 32'(s % 2));
      if (s % 2 == 1) begin
        chk("n3_gid", s, 32'(gid3), (s % 4 == 1) ? 2 : 0);
        chk("n3_winc", s, 32'(winc3), 1);
        chk("n3_wdata", s, 32'(wdata3), (s % 4 == 1) ? 32'hC2 : 32'hC0);
      end
    end
    v3 = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
